// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: turns 64-bit load/store requests from the pipeline (cpu)
// and the debug/loader port (dbg) into eight little-endian byte cycles on a
// byte-wide data memory, with round-robin arbitration between the two ports.
module dmem_access_ctrl #(
  parameter int MEM_BYTES = 8192,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [63:0]   cpu_addr,
  input  logic [63:0]   cpu_wdata,
  output logic [63:0]   cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_err,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [63:0]   dbg_addr,
  input  logic [63:0]   dbg_wdata,
  output logic [63:0]   dbg_rdata,
  output logic          dbg_done,
  output logic          dbg_err,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [7:0]    mem_rdata
);

  // Highest legal doubleword base address: base+7 must stay inside memory.
  localparam logic [AW-1:0] MAX_BASE = AW'(MEM_BYTES - 8);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t        state, state_nx;
  logic [3:0]    k;          // byte counter; READ uses k==8 as the drain cycle
  logic          gnt_dbg;    // port owning the current transaction
  logic          last_dbg;   // port granted by the previous transaction
  logic          we_l;
  logic [AW-1:0] addr_l;
  logic [63:0]   wdata_l;
  logic [63:0]   shadow;

  logic          any_req, pick_dbg, sel_we, sel_err;
  logic [63:0]   sel_addr, sel_wdata;
  logic          fin, fin_dbg, fin_err;
  logic [2:0]    slot;

  // Round-robin pick and range check of the candidate request in IDLE.
  always_comb begin
    any_req   = cpu_req | dbg_req;
    pick_dbg  = dbg_req & (~cpu_req | ~last_dbg);
    sel_we    = pick_dbg ? dbg_we    : cpu_we;
    sel_addr  = pick_dbg ? dbg_addr  : cpu_addr;
    sel_wdata = pick_dbg ? dbg_wdata : cpu_wdata;
    sel_err   = (|sel_addr[63:AW]) | (sel_addr[AW-1:0] > MAX_BASE);
  end

  // Next-state logic, completion decode and memory strobes.
  always_comb begin
    state_nx  = state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    slot      = k[2:0] - 3'd1;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (sel_err)     state_nx = DONE;
          else if (sel_we) state_nx = WRITE;
          else             state_nx = READ;
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = addr_l + {{(AW-3){1'b0}}, k[2:0]};
        mem_wdata = wdata_l[{k[2:0], 3'b000} +: 8];
        if (k == 4'd7) state_nx = DONE;
      end
      READ: begin
        if (k == 4'd8) begin
          state_nx = DONE;
        end else begin
          mem_re   = 1'b1;
          mem_addr = addr_l + {{(AW-3){1'b0}}, k[2:0]};
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    fin     = (state != DONE) && (state_nx == DONE);
    fin_dbg = (state == IDLE) ? pick_dbg : gnt_dbg;
    fin_err = (state == IDLE) && sel_err;
  end

  assign cpu_stall = cpu_req & ~cpu_done;

  // State, latched request, byte assembly and registered port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      gnt_dbg   <= 1'b0;
      last_dbg  <= 1'b1;
      we_l      <= 1'b0;
      addr_l    <= '0;
      wdata_l   <= '0;
      shadow    <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      dbg_done  <= 1'b0;
      dbg_err   <= 1'b0;
    end else begin
      state    <= state_nx;
      cpu_done <= fin & ~fin_dbg;
      dbg_done <= fin & fin_dbg;
      cpu_err  <= fin & ~fin_dbg & fin_err;
      dbg_err  <= fin & fin_dbg & fin_err;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_dbg <= pick_dbg;
            we_l    <= sel_we;
            addr_l  <= sel_addr[AW-1:0];
            wdata_l <= sel_wdata;
            k       <= '0;
          end
        end
        WRITE: k <= k + 4'd1;
        READ: begin
          k <= k + 4'd1;
          if (k != 4'd0) shadow[{slot, 3'b000} +: 8] <= mem_rdata;
          if (k == 4'd8) begin
            if (gnt_dbg) dbg_rdata <= {mem_rdata, shadow[55:0]};
            else         cpu_rdata <= {mem_rdata, shadow[55:0]};
          end
        end
        DONE: last_dbg <= gnt_dbg;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer and arbiter for the byte-wide data memory (8192 x 8 bits) behind the MEM stage. Turns 64-bit load/store requests into eight single-byte memory cycles, little-endian, and shares the memory port between the pipeline (cpu port) and a debug/loader port (dbg port) using round-robin arbitration. The pipeline stalls on `cpu_stall` until `cpu_done`.

## Interface
- `MEM_BYTES`, 8192: data memory depth in bytes; `mem_addr` width is log2(MEM_BYTES) = 13.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `cpu_req` input 1: pipeline request; held until `cpu_done`.
- `cpu_we` input 1: 1 = store (STUR), 0 = load (LDUR).
- `cpu_addr` input 64: byte address of the doubleword (ALU result).
- `cpu_wdata` input 64: store data.
- `cpu_rdata` output 64: load data, registered.
- `cpu_done` output 1: one-cycle completion pulse.
- `cpu_err` output 1: valid with `cpu_done`; 1 = address out of range, no access made.
- `cpu_stall` output 1: `cpu_req & ~cpu_done`, combinational.
- `dbg_req`, `dbg_we`, `dbg_addr`[64], `dbg_wdata`[64]: inputs, same meaning for the debug/loader port.
- `dbg_rdata`[64], `dbg_done`, `dbg_err`: outputs, same meaning for the debug port.
- `mem_addr` output 13: byte address to the memory.
- `mem_wdata` output 8: byte to write.
- `mem_we` output 1: write strobe; the byte is written at the end of the cycle.
- `mem_re` output 1: read strobe; `mem_rdata` is valid in the following cycle.
- `mem_rdata` input 8: read data from the memory.

## Operation
- FSM states: IDLE, WRITE, READ, DONE.
- **IDLE:**
  - Sample the requests.
  - If only one port requests, grant it.
  - If both request, grant the port that was not granted last. The `last` flag resets to dbg, so the cpu wins the first tie.
  - On grant, latch `we`, `addr` and `wdata`, and clear the byte counter `k`.
- **Range check at grant:**
  - Error when `addr[63:13] != 0` or `addr[12:0] > MEM_BYTES-8`.
  - Error goes straight to DONE with err=1. No memory strobe is issued.
- **WRITE:**
  - For k = 0..7: `mem_we`=1, `mem_addr`=addr+k, `mem_wdata`=wdata[8k+7:8k].
  - After k=7, go to DONE.
- **READ:**
  - For k = 0..7: `mem_re`=1, `mem_addr`=addr+k.
  - The byte returned in the next cycle is stored into rdata_shadow[8k+7:8k].
  - After issuing k=7, spend one drain cycle with no strobe to capture byte 7, then go to DONE.
- **DONE:**
  - Pulse `done` on the granted port only.
  - Load `<port>_rdata` from the shadow register (reads only), drive `err`, update `last`, return to IDLE.
- `<port>_rdata` holds its value until that port's next successful read completes. Writes and errors leave it unchanged.
- Request fields changing after grant are ignored; the latched copy is used.
- A requester deasserts `req` on the edge at which it samples `done`=1. If `req` is still high in the following IDLE cycle, a new transaction starts.
- Deasserting `req` mid-transaction does not abort it.
- `mem_we` and `mem_re` are never high together, and are never high outside WRITE/READ.

## Timing
- Reset values: all outputs 0, state IDLE, `last`=dbg, shadow and latched fields 0. Reset wins over any state.
- Reset mid-transaction: the FSM is in IDLE in the next cycle and no further strobes are issued. Bytes already written stay written; there is no rollback. No `done` is issued.
- Cycle 0 is the IDLE cycle in which the grant happens.
- Write: strobes in cycles 1–8, `done` in cycle 9. Occupancy is 10 cycles including the return to IDLE.
- Read: strobes in cycles 1–8, drain in cycle 9, `done` in cycle 10 with `rdata` valid in that same cycle.
- Error: `done`+`err` in cycle 1.
- Earliest next grant: the cycle after `done`.
- Back-to-back contention: with both ports requesting continuously, grants alternate cpu, dbg, cpu, …
- Address arithmetic: addr+k uses 13 bits. There is no wrap-around, because the range check guarantees addr+7 ≤ 8191.

## Test plan
- Store cpu_addr=0x10, wdata=0x1122334455667788: `mem_we` in cycles 1–8 at addresses 0x10..0x17 with bytes 88,77,…,11; `cpu_done` in cycle 9; `cpu_stall`=1 in cycles 0–8.
- Load the same address: `mem_re` at 0x10..0x17; `cpu_rdata`=0x1122334455667788 with `cpu_done` in cycle 10.
- Range errors:
  - addr=0x1FF9 → `cpu_done`=1, `cpu_err`=1 in cycle 1, no strobes.
  - addr=0x1FF8 succeeds, touching 0x1FF8..0x1FFF.
  - addr=0x1_0000_0000 → err.
- Contention: both ports request from reset; grant order cpu, dbg, cpu; `dbg_done` never coincides with `cpu_done`; `dbg_rdata` is unaffected by cpu loads.
- Reset asserted in write cycle 4: bytes 0–3 are written, no strobe in the following cycle, no `done`, all outputs 0. A new request after reset completes normally.
- Hold `req` high through `done`: a second transaction starts in the IDLE cycle after `done`, with the second `done` 10 cycles later for a write.
